// File: rtl/mmio_port_responder.sv
// MMIO responder: OUT/IN/STATUS window on the ME-stage data bus, owns board I/O pins.
// Optional input debounce is enabled by defining MMIO_DEBOUNCE_EN.
module mmio_port_responder #(
   parameter logic [31:0] BASE_ADDR       = 32'h1001_0000,
   parameter logic [31:0] PORT_OUT_RESET  = 32'h0000_0000,
   parameter int          DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Hit,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic        InChanged
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("DEBOUNCE_CYCLES must be >= 1");
   end

   logic [31:0] port_out_q, port_out_d;
   logic [7:0]  sync1_q, sync1_d;
   logic [7:0]  sync2_q, sync2_d;
   logic [7:0]  in_q, in_d;
   logic        changed_q, changed_d;
   logic        load_in;

   logic sel_out, sel_in, sel_st, sel_any;
   logic st_clr, st_set;

   assign sel_out = (Address == BASE_ADDR);
   assign sel_in  = (Address == BASE_ADDR + 32'd4);
   assign sel_st  = (Address == BASE_ADDR + 32'd8);
   assign sel_any = sel_out | sel_in | sel_st;

   assign Hit       = sel_any & (MemRead | MemWrite);
   assign PortOut   = port_out_q;
   assign InChanged = changed_q;

   always_comb begin
      ReadData = '0;
      if (MemRead) begin
         unique case (1'b1)
            sel_out: ReadData = port_out_q;
            sel_in:  ReadData = {24'b0, in_q};
            sel_st:  ReadData = {30'b0, in_q != sync2_q, changed_q};
            default: ReadData = '0;
         endcase
      end
   end

`ifdef MMIO_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Count edges sync2 has held a new value; accept it once it has lasted long enough.
   always_comb begin
      cnt_d   = '0;
      load_in = 1'b0;
      if ((sync1_q != sync2_q) || (sync2_q == in_q)) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
         load_in = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign load_in = 1'b1;
`endif

   always_comb begin
      port_out_d = port_out_q;
      if (MemWrite && sel_out) port_out_d = WriteData;
      sync1_d   = PortIn;
      sync2_d   = sync1_q;
      in_d      = load_in ? sync2_q : in_q;
      st_set    = load_in && (sync2_q != in_q);
      st_clr    = MemWrite && sel_st && WriteData[0];
      // A new change in the same cycle as a clear must not be lost.
      changed_d = st_set | (changed_q & ~st_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         port_out_q <= PORT_OUT_RESET;
         sync1_q    <= '0;
         sync2_q    <= '0;
         in_q       <= '0;
         changed_q  <= 1'b0;
      end else begin
         port_out_q <= port_out_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         in_q       <= in_d;
         changed_q  <= changed_d;
      end
   end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: vector table with scoreboard
// plus hand sequences for input latency, W1C race, async reset and debounce.
module tb_mmio_port_responder;

   localparam logic [31:0] B   = 32'h1001_0000;
   localparam logic [31:0] POR = 32'h0000_00F0;
`ifdef MMIO_DEBOUNCE_EN
   localparam int LAT = 2 + 4;
`else
   localparam int LAT = 3;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Hit;
   logic [7:0]  PortIn;
   logic [31:0] PortOut;
   logic        InChanged;

   mmio_port_responder #(
      .BASE_ADDR      (B),
      .PORT_OUT_RESET (POR),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ReadData  (ReadData),
      .Hit       (Hit),
      .PortIn    (PortIn),
      .PortOut   (PortOut),
      .InChanged (InChanged)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wd;
      logic        we;
      logic        re;
      logic [31:0] rd;
      logic        hit;
      logic [31:0] out;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic        hit;
      logic [31:0] out;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   vec_t tbl[13];
   exp_t sb[$];
   exp_t e;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic re);
      Address   = a;
      WriteData = wd;
      MemWrite  = we;
      MemRead   = re;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      PortIn = 8'h00;
      drive(32'h0, 32'h0, 1'b0, 1'b0);

      tbl[0]  = '{B,        32'hDEAD_BEEF, 1, 0, 32'h0,         1, 32'hDEAD_BEEF};
      tbl[1]  = '{B,        32'h0,         0, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
      tbl[2]  = '{B,        32'h1234_5678, 1, 1, 32'hDEAD_BEEF, 1, 32'h1234_5678};
      tbl[3]  = '{B + 4,    32'h0,         0, 1, 32'h0,         1, 32'h1234_5678};
      tbl[4]  = '{B + 4,    32'hFF,        1, 0, 32'h0,         1, 32'h1234_5678};
      tbl[5]  = '{B + 8,    32'h0,         0, 1, 32'h0,         1, 32'h1234_5678};
      tbl[6]  = '{B + 32'hC, 32'h0,        0, 1, 32'h0,         0, 32'h1234_5678};
      tbl[7]  = '{B + 32'hC, 32'h5555_AAAA, 1, 0, 32'h0,        0, 32'h1234_5678};
      tbl[8]  = '{B + 2,    32'h0,         0, 1, 32'h0,         0, 32'h1234_5678};
      tbl[9]  = '{B + 2,    32'h0,         1, 0, 32'h0,         0, 32'h1234_5678};
      tbl[10] = '{B,        32'h0,         0, 0, 32'h0,         0, 32'h1234_5678};
      tbl[11] = '{32'h0,    32'h0,         0, 1, 32'h0,         0, 32'h1234_5678};
      tbl[12] = '{B ^ 32'h0001_0000, 32'h1, 1, 1, 32'h0,        0, 32'h1234_5678};

      // Reset state
      #2;
      chk("rst PortOut", PortOut, POR);
      chk("rst InChanged", {31'b0, InChanged}, 32'h0);
      chk("rst Hit", {31'b0, Hit}, 32'h0);
      chk("rst ReadData", ReadData, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post-rst PortOut", PortOut, POR);

      // Table-driven bus accesses through the scoreboard
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].addr, tbl[i].wd, tbl[i].we, tbl[i].re);
         sb.push_back('{tbl[i].rd, tbl[i].hit, tbl[i].out});
         #1;
         e = sb.pop_front();
         chk($sformatf("v%0d ReadData", i), ReadData, e.rd);
         chk($sformatf("v%0d Hit", i), {31'b0, Hit}, {31'b0, e.hit});
         tick();
         chk($sformatf("v%0d PortOut", i), PortOut, e.out);
      end
      drive(32'h0, 32'h0, 1'b0, 1'b0);

      // Input latency: 0x00 -> 0xA5
      PortIn = 8'hA5;
      drive(B + 4, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < LAT - 1; i++) tick();
      #1;
      chk("lat early IN", ReadData, 32'h0);
      Address = B + 8;
      #1;
      chk("lat early STATUS", ReadData, 32'h2);
      Address = B + 4;
      tick();
      #1;
      chk("lat IN", ReadData, 32'h0000_00A5);
      Address = B + 8;
      #1;
      chk("lat STATUS", ReadData, 32'h1);
      chk("lat InChanged", {31'b0, InChanged}, 32'h1);

      // W1C clear racing with a new change: set wins
      drive(32'h0, 32'h0, 1'b0, 1'b0);
      PortIn = 8'h5A;
      for (int i = 0; i < LAT - 1; i++) tick();
      drive(B + 8, 32'h1, 1'b1, 1'b0);
      tick();
      chk("race InChanged", {31'b0, InChanged}, 32'h1);
      drive(B + 8, 32'h1, 1'b1, 1'b0);
      tick();
      chk("w1c InChanged", {31'b0, InChanged}, 32'h0);
      drive(B + 8, 32'h0, 1'b0, 1'b1);
      #1;
      chk("w1c STATUS", ReadData, 32'h0);
      drive(B + 4, 32'h0, 1'b0, 1'b1);
      #1;
      chk("race IN", ReadData, 32'h0000_005A);

      // Async reset mid-cycle with a store in flight
      drive(32'h0, 32'h0, 1'b0, 1'b0);
      PortIn = 8'h3C;
      for (int i = 0; i < LAT + 1; i++) tick();
      chk("pre-rst InChanged", {31'b0, InChanged}, 32'h1);
      drive(B, 32'h0000_CAFE, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("async PortOut", PortOut, POR);
      chk("async InChanged", {31'b0, InChanged}, 32'h0);
      drive(B + 4, 32'h0, 1'b0, 1'b1);
      #1;
      chk("async IN", ReadData, 32'h0);
      @(negedge clk);
      PortIn = 8'h00;
      reset = 1'b0;
      #1;
      chk("after-rst IN", ReadData, 32'h0);
      tick();
      chk("store lost", PortOut, POR);

`ifdef MMIO_DEBOUNCE_EN
      // Short glitch filtered, long hold accepted
      PortIn = 8'hFF;
      for (int i = 0; i < 3; i++) tick();
      PortIn = 8'h00;
      for (int i = 0; i < 8; i++) tick();
      #1;
      chk("glitch IN", ReadData, 32'h0);
      chk("glitch InChanged", {31'b0, InChanged}, 32'h0);
      PortIn = 8'hFF;
      for (int i = 0; i < 5; i++) tick();
      #1;
      chk("hold early IN", ReadData, 32'h0);
      tick();
      #1;
      chk("hold IN", ReadData, 32'h0000_00FF);
      chk("hold InChanged", {31'b0, InChanged}, 32'h1);
`endif

      drive(32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
